// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer blocks.
// Both the write-side and read-side pointer logic import this package so the
// default geometry and the binary-to-Gray mapping stay identical on both sides.
package fifo_pkg;

  // Default number of FIFO entries (power of two).
  localparam int FIFO_DEFAULT_DEPTH = 1024;

  // Default distance below depth at which almost_full asserts.
  localparam int FIFO_DEFAULT_AF_MARGIN = 4;

  // Reflected binary Gray code: adjacent values differ in exactly one bit, so
  // a pointer crossing clock domains can never be sampled as a wild value.
  // Callers truncate the 32-bit result to their pointer width; the low bits
  // are correct because the mapping only looks at each bit and its upper
  // neighbour.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Gray-to-binary converter for FIFO pointers.
// Purely combinational prefix XOR: each binary bit is the XOR of the Gray bit
// at that position and every Gray bit above it. Used for the synchronized
// read pointer here and for the synchronized write pointer on the read side.
module gray2bin #(
  parameter int width = 4
) (
  input  logic [width-1:0] gray,
  output logic [width-1:0] bin
);

  // Walk from the MSB down, carrying the running XOR of all higher Gray bits.
  always_comb begin
    logic acc;
    bin = '0;
    acc = 1'b0;
    for (int i = width - 1; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full-flag generator for the asynchronous FIFO.
//
// Keeps the binary write pointer, registers the Gray copy that crosses into
// the read domain, drives the memory write address/strobe, and compares
// against the read Gray pointer (already synchronized into clk) to produce
// full, almost_full, a conservative fill level and a sticky overflow flag.
//
// Build option: define FIFO_WPTR_ALMOST_FULL_EN to get a real almost_full
// comparator against af_thresh. Without it, almost_full simply mirrors full
// and af_thresh has no effect. The port list is identical either way.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter  int depth     = FIFO_DEFAULT_DEPTH,
  parameter  int af_thresh = depth - FIFO_DEFAULT_AF_MARGIN,
  localparam int A         = $clog2(depth)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [A:0]   rptr_gray_sync,
  output logic [A:0]   wptr_gray,
  output logic [A-1:0] waddr,
  output logic         wr_ok,
  output logic         full,
  output logic         almost_full,
  output logic [A:0]   wlevel,
  output logic         overflow
);

  localparam int W = A + 1;

  // Reject geometries the pointer arithmetic cannot handle: the full test
  // needs at least two address bits plus the wrap bit, and both pointers
  // rely on natural power-of-two wrap.
  if (depth < 4 || (depth & (depth - 1)) != 0 ||
      af_thresh < 1 || af_thresh > depth) begin : g_param_error
    $error("fifo_wptr_full: illegal depth/af_thresh combination");
  end

  logic [A:0] wbin;
  logic [A:0] wbin_next;
  logic [A:0] wgray_next;
  logic [A:0] rbin;
  logic [A:0] wlevel_next;
  logic       full_next;

  // Convert the synchronized read Gray pointer back to binary for the level.
  gray2bin #(
    .width(W)
  ) u_rptr_gray2bin (
    .gray(rptr_gray_sync),
    .bin (rbin)
  );

  // The memory may only be written when a slot is free; a full FIFO drops it.
  assign wr_ok = wr_en & ~full;
  assign waddr = wbin[A-1:0];

  // Next-state pointer arithmetic. Full is detected when the next write
  // Gray pointer equals the read pointer with its two MSBs inverted, i.e.
  // the writer is exactly one lap ahead. The level uses the synchronized
  // (therefore stale) read pointer, so it can only over-estimate occupancy.
  always_comb begin
    wbin_next   = wbin + {{A{1'b0}}, wr_ok};
    wgray_next  = W'(bin2gray(32'(wbin_next)));
    full_next   = (wgray_next == {~rptr_gray_sync[A:A-1], rptr_gray_sync[A-2:0]});
    wlevel_next = wbin_next - rbin;
  end

  // Pointer, flags and level registers; all clear immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin      <= '0;
      wptr_gray <= '0;
      full      <= 1'b0;
      wlevel    <= '0;
      overflow  <= 1'b0;
    end else begin
      wbin      <= wbin_next;
      wptr_gray <= wgray_next;
      full      <= full_next;
      wlevel    <= wlevel_next;
      overflow  <= overflow | (wr_en & full);
    end
  end

`ifdef FIFO_WPTR_ALMOST_FULL_EN
  localparam logic [A:0] AF_LIMIT = W'(af_thresh);

  logic almost_full_next;

  // Threshold compare on the next level so the flag lines up with wlevel.
  always_comb begin
    almost_full_next = (wlevel_next >= AF_LIMIT);
  end

  // Registered almost_full, cleared with the rest of the write-side state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= almost_full_next;
    end
  end
`else
  assign almost_full = full;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed self-checking bench for fifo_wptr_full (depth 8, af_thresh 6).
// Expected almost_full follows FIFO_WPTR_ALMOST_FULL_EN: the threshold
// compare when defined, otherwise a copy of full.
module tb_fifo_wptr_full;

  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [3:0] rptr_gray_sync;
  logic [3:0] wptr_gray;
  logic [2:0] waddr;
  logic       wr_ok;
  logic       full;
  logic       almost_full;
  logic [3:0] wlevel;
  logic       overflow;

  int compared   = 0;
  int mismatched = 0;

  // 4-bit Gray sequence for binary 0..15, written out by hand.
  logic [3:0] grayTab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                               4'b0110, 4'b0111, 4'b0101, 4'b0100,
                               4'b1100, 4'b1101, 4'b1111, 4'b1110,
                               4'b1010, 4'b1011, 4'b1001, 4'b1000};

  fifo_wptr_full #(
    .depth    (DEPTH),
    .af_thresh(AF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .rptr_gray_sync(rptr_gray_sync),
    .wptr_gray     (wptr_gray),
    .waddr         (waddr),
    .wr_ok         (wr_ok),
    .full          (full),
    .almost_full   (almost_full),
    .wlevel        (wlevel),
    .overflow      (overflow)
  );

  // Free-running write clock, posedges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic expAf(input int level, input logic expFull);
`ifdef FIFO_WPTR_ALMOST_FULL_EN
    return (level >= AF);
`else
    return expFull;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [3:0] rg);
    wr_en          = w;
    rptr_gray_sync = rg;
  endtask

  // Wait for the next active edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [3:0] g, input logic [2:0] a,
                          input logic f, input logic af, input logic [3:0] lvl,
                          input logic ov);
    checkOutput({tag, ".wptr_gray"}, 32'(wptr_gray), 32'(g));
    checkOutput({tag, ".waddr"}, 32'(waddr), 32'(a));
    checkOutput({tag, ".full"}, 32'(full), 32'(f));
    checkOutput({tag, ".almost_full"}, 32'(almost_full), 32'(af));
    checkOutput({tag, ".wlevel"}, 32'(wlevel), 32'(lvl));
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(ov));
  endtask

  initial begin
    // Reset held with a write request pending: outputs zero, strobe follows wr_en.
    rst = 1'b1;
    applyStimulus(1'b1, 4'b0000);
    #8;
    checkAll("reset", 4'b0000, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("reset.wr_ok", 32'(wr_ok), 32'd1);
    #4;
    rst = 1'b0;

    // First accepted write lands on the first edge after release.
    tick();
    checkAll("w1", 4'b0001, 3'd1, 1'b0, expAf(1, 1'b0), 4'd1, 1'b0);

    // Writes 2..8 with the read pointer parked at zero.
    for (int k = 2; k <= 8; k++) begin
      tick();
      checkOutput($sformatf("fill%0d.wlevel", k), 32'(wlevel), 32'(k));
      checkOutput($sformatf("fill%0d.wptr_gray", k), 32'(wptr_gray), 32'(grayTab[k]));
      checkOutput($sformatf("fill%0d.almost_full", k), 32'(almost_full),
                  32'(expAf(k, k == 8)));
      checkOutput($sformatf("fill%0d.full", k), 32'(full), 32'(k == 8));
    end
    checkAll("full8", 4'b1100, 3'd0, 1'b1, 1'b1, 4'd8, 1'b0);

    // Write attempted while full is refused and flagged.
    checkOutput("wfull.wr_ok", 32'(wr_ok), 32'd0);
    tick();
    checkAll("wfull", 4'b1100, 3'd0, 1'b1, 1'b1, 4'd8, 1'b1);

    // Overflow stays set with no further writes.
    applyStimulus(1'b0, 4'b0000);
    tick();
    checkOutput("ovsticky", 32'(overflow), 32'd1);

    // Reader frees one slot: full drops and level reads 7 one edge later.
    applyStimulus(1'b0, 4'b0001);
    tick();
    checkAll("rel", 4'b1100, 3'd0, 1'b0, expAf(7, 1'b0), 4'd7, 1'b1);

    // Writing into that slot fills the FIFO again.
    applyStimulus(1'b1, 4'b0001);
    #1;
    checkOutput("refill.wr_ok", 32'(wr_ok), 32'd1);
    tick();
    checkAll("refill", 4'b1101, 3'd1, 1'b1, 1'b1, 4'd8, 1'b1);

    // Clean restart before the wrap walk.
    applyStimulus(1'b0, 4'b0000);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    checkAll("rst2", 4'b0000, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);

    // 16 writes, reader trailing by 3: Gray pointer walks the full cycle.
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b1, (k >= 3) ? grayTab[k - 3] : 4'b0000);
      tick();
      checkOutput($sformatf("walk%0d.wptr_gray", k), 32'(wptr_gray), 32'(grayTab[k % 16]));
      checkOutput($sformatf("walk%0d.wlevel", k), 32'(wlevel), 32'((k < 3) ? k : 3));
      checkOutput($sformatf("walk%0d.full", k), 32'(full), 32'd0);
    end
    checkOutput("walk.overflow", 32'(overflow), 32'd0);
    checkOutput("walk.almost_full", 32'(almost_full), 32'd0);

    // Bring both pointers back to 0, then write five entries.
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 4'b0000);
      tick();
    end
    checkAll("lvl5", 4'b0111, 3'd5, 1'b0, expAf(5, 1'b0), 4'd5, 1'b0);

    // Asynchronous reset mid-stream clears everything before the next edge.
    #2;
    rst = 1'b1;
    #1;
    checkAll("arst", 4'b0000, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("arst.wr_ok", 32'(wr_ok), 32'd1);
    tick();
    checkAll("arst_hold", 4'b0000, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 4'b0000);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_full.md
# fifo_wptr_full

Write-domain pointer and full-flag generator for the asynchronous FIFO. It keeps the binary write pointer, produces the registered Gray write pointer handed to the write-to-read 2-FF synchronizer, and drives the write address and write strobe for the dual-port memory. It compares against the read Gray pointer already synchronized into the write clock domain to derive full, almost-full, fill level and a sticky overflow flag.

## Interface
- `depth`, 1024: FIFO entries; power of two, ≥ 4. A = $clog2(depth).
- `af_thresh`, depth-4: almost_full asserts when the fill level is ≥ this value; range 1..depth.
- `clk`  in  1  write-domain clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `wr_en`  in  1  write request.
- `rptr_gray_sync`  in  A+1  read Gray pointer, already synchronized into `clk`.
- `wptr_gray`  out  A+1  registered Gray write pointer; feeds the synchronizer.
- `waddr`  out  A  binary memory write address (low A bits of the binary pointer).
- `wr_ok`  out  1  combinational `wr_en & ~full`; memory write strobe.
- `full`  out  1  registered full flag.
- `almost_full`  out  1  registered; see Configuration.
- `wlevel`  out  A+1  registered conservative fill level, 0..depth.
- `overflow`  out  1  sticky: a write was attempted while full.

## Operation
- State: `wbin` (A+1 bits), `wptr_gray`, `full`, `almost_full`, `wlevel`, `overflow`.
- `wbin_next = wbin + wr_ok`, modulo 2^(A+1).
- `wgray_next = (wbin_next >> 1) ^ wbin_next`. Register `wptr_gray <= wgray_next` so only one bit changes per increment.
- `full_next = (wgray_next == {~rptr_gray_sync[A:A-1], rptr_gray_sync[A-2:0]})`.
- `rbin = gray2bin(rptr_gray_sync)`.
- `wlevel_next = wbin_next - rbin`, computed in A+1 bits with wrap.
- `almost_full_next = (wlevel_next >= af_thresh)`.
- `overflow <= overflow | (wr_en & full)`. It is cleared only by `rst`.
- Writes while full are dropped: the pointer and memory are unchanged.
- No FSM. The pointer wraps naturally: 2*depth increments return `wptr_gray` to 0.

## Timing
- Reset values: every output is 0 (`wptr_gray`, `waddr`, `full`, `almost_full`, `wlevel`, `overflow`). `wr_ok` = `wr_en` while in reset.
- Reset applied mid-operation: outputs clear immediately (asynchronous). Any in-flight write is lost. The read side must be reset together with this block.
- Write latency: a write accepted at edge N updates `waddr`, `wptr_gray` and `wlevel` at edge N.
- `full` asserts on the same edge that accepts the last free slot. A `wr_en` on the following cycle is rejected.
- Release of full is pessimistic. `full` clears one edge after `rptr_gray_sync` changes, which is at least 2 `clk` edges after the read-side pointer moves (synchronizer delay).
- Simultaneous write and read-pointer advance in one cycle: both enter `wlevel_next`, and the level stays the same.
- `wlevel` never exceeds depth and is never an under-estimate of true occupancy.

## Configuration
- `FIFO_WPTR_ALMOST_FULL_EN` defined: the `almost_full` register and comparator are present, as described above.
- `FIFO_WPTR_ALMOST_FULL_EN` undefined: no comparator is built and `almost_full` is tied to `full`. The `af_thresh` parameter is ignored.
- The port list is the same in both cases.

## Structure
- Package `fifo_pkg`: `FIFO_DEFAULT_DEPTH` = 1024, `FIFO_DEFAULT_AF_MARGIN` = 4, and the function `bin2gray`. The read-side pointer block uses the same definitions.
- Sub-module `gray2bin` (parameter width A+1), a combinational prefix-XOR. It is instantiated once for `rptr_gray_sync` and is also reused on the read side.

## Test plan
(depth=8, af_thresh=6, `FIFO_WPTR_ALMOST_FULL_EN` defined unless stated)
- Reset with `wr_en`=1 → all outputs 0. After release, the first edge with `wr_en`=1 gives `waddr`=1, `wptr_gray`=4'b0001, `wlevel`=1.
- `rptr_gray_sync`=0 and 8 consecutive writes → `almost_full`=1 after the 6th edge. After the 8th edge: `full`=1, `wlevel`=8, `wptr_gray`=4'b1100.
- Write while full → `wr_ok`=0, `wptr_gray` stays 4'b1100, `overflow`=1 and stays 1 afterwards.
- Full, then drive `rptr_gray_sync`=4'b0001 → `full`=0 and `wlevel`=7 one edge later. A write on that cycle → `full`=1 again.
- 16 writes interleaved with reads that keep the level ≤ 3 → `wptr_gray` follows the 4-bit Gray sequence back to 0000. `full` is never set and `overflow`=0.
- Assert `rst` mid-stream at `wlevel`=5 → all outputs clear asynchronously before the next edge. Rebuild with the macro undefined → `almost_full` equals `full` on every cycle.
